retire_arb9_rr: RTL and testbench
=================================

RETIRE_ARB9_RR -- requirements
Module: retire_arb9_rr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, payload width per requester.
REQ-002 SHALL have parameter N_REQ, default 9, requester count, legal range 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_flush, input, 1, synchronous clear of all buffered entries.
REQ-006 SHALL have port i_valid, input, N_REQ, per-requester offer.
REQ-007 SHALL have port i_data, input, N_REQ*DATA_WIDTH, requester k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port o_ready, output, N_REQ, per-requester slot empty.
REQ-009 SHALL have port o_valid, output, 1, merged output holds an entry.
REQ-010 SHALL have port o_data, output, DATA_WIDTH, merged payload.
REQ-011 SHALL have port o_src, output, 4, index of the requester that supplied o_data.
REQ-012 SHALL have port i_ready, input, 1, downstream accept.

Function
REQ-013 SHALL hold one slot per requester, each in state EMPTY or FULL; o_ready[k] SHALL equal (slot k EMPTY), with no combinational path from i_valid or i_ready.
REQ-014 SHALL move slot k EMPTY->FULL, capturing i_data[k], on a clock edge where i_valid[k] & o_ready[k].
REQ-015 SHALL give each slot at most one transfer per two cycles: a slot cannot fill and drain on the same edge.
REQ-016 SHALL have an output register in state IDLE or VALID; it SHALL load when (IDLE or i_ready) and at least one slot is FULL.
REQ-017 SHALL grant round-robin among FULL slots, searching upward from pointer ptr with wrap at N_REQ-1 to 0; ptr SHALL become (granted+1) mod N_REQ on each load.
REQ-018 SHALL, on load, copy the granted slot's payload to o_data and its index to o_src, and set the granted slot EMPTY on the same edge.
REQ-019 SHALL, when o_valid & !i_ready, keep o_data and o_src stable, issue no grant, and leave ptr unchanged.
REQ-020 SHALL, when o_valid & i_ready and no slot is FULL, go to IDLE with o_valid 0 on the next edge.
REQ-021 SHALL have a minimum latency of 2 edges, input handshake to o_valid, and sustain 1 output per cycle when 2 or more slots are FULL.
REQ-022 SHALL, on i_flush, set all slots EMPTY and o_valid 0 and ignore same-cycle captures and loads; ptr SHALL be unchanged.

Reset
REQ-023 SHALL, on rst, set all slots EMPTY (o_ready all 1s), o_valid 0, o_data 0, o_src 0 and ptr 0.
REQ-024 SHALL give rst priority over i_flush and all handshakes; entries in flight during rst are discarded.

Configuration
REQ-025 SHALL have macro RETIRE_ARB_GRANT_CNT_EN; when defined, it adds output o_grant_cnt (N_REQ*16), a per-requester saturating count of loads, cleared by rst but not by i_flush, holding at 16'hFFFF.
REQ-026 SHALL, without RETIRE_ARB_GRANT_CNT_EN, have no o_grant_cnt port and no counter logic.

Structure
REQ-027 SHALL take N_REQ default, SRC_W=4 and the slot/output state encodings from shared package retire_arb_pkg.
REQ-028 SHALL implement one slot as sub-module retire_arb_slot, instantiated N_REQ times; arbitration and the output register stay in the top level.

Verification
REQ-029 SHALL cover reset: assert rst mid-traffic with 3 slots FULL -> next cycle o_ready=9'h1FF, o_valid=0, o_src=0; the first later grant goes to requester 0 if offered.
REQ-030 SHALL cover round-robin: slots 2, 5 and 8 FULL, i_ready=1 -> o_src sequence 2, 5, 8 on consecutive cycles; refill all three -> 2, 5, 8 again.
REQ-031 SHALL cover wrap: ptr=8 with slots 0 and 8 FULL -> grant 8 then 0.
REQ-032 SHALL cover backpressure: i_ready=0 for 5 cycles with o_valid=1, o_data=12'hA5C, o_src=3 -> o_data and o_src stable and no slot drained; i_ready=1 -> next entry appears the following cycle.
REQ-033 SHALL cover flush with a simultaneous offer: i_flush=1 with i_valid[4]=1 -> next cycle slot 4 EMPTY and o_valid=0.
REQ-034 SHALL cover the counter with RETIRE_ARB_GRANT_CNT_EN defined: 70000 grants to requester 1 -> o_grant_cnt[31:16]=16'hFFFF.

Source files
------------

// File: rtl/retire_arb_pkg.sv
// Shared definitions for the retire_arb9_rr merge arbiter: default requester count,
// source-index width, slot/output state encodings and the round-robin pointer helper.
package retire_arb_pkg;

    localparam int unsigned N_REQ_DEFAULT = 9;
    localparam int unsigned SRC_W         = 4;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

    typedef enum logic {
        OutIdle  = 1'b0,
        OutValid = 1'b1
    } out_state_e;

    // Index of the requester after idx, wrapping at n-1 back to 0.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx,
                                                  input int unsigned      n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/retire_arb_slot.sv
// One single-entry requester buffer: fills from its requester when empty and
// drains to the arbiter when granted. Flush empties it; rst also clears the payload.
module retire_arb_slot
    import retire_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] rd_data
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Fill only when empty, drain only when full, so the two never share an edge.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = SlotEmpty;
        end else if (state_q == SlotEmpty) begin
            if (wr_en) begin
                state_d = SlotFull;
                data_d  = wr_data;
            end
        end else if (rd_en) begin
            state_d = SlotEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SlotEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign full    = (state_q == SlotFull);
    assign rd_data = data_q;

endmodule

// File: rtl/retire_arb9_rr.sv
// Round-robin merge of N_REQ single-entry requester slots into one registered output.
// Optional per-requester saturating grant counters are enabled by RETIRE_ARB_GRANT_CNT_EN.
module retire_arb9_rr
    import retire_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned N_REQ      = N_REQ_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic [N_REQ-1:0]            i_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]            o_ready,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
`ifdef RETIRE_ARB_GRANT_CNT_EN
    output logic [SRC_W-1:0]            o_src,
    output logic [N_REQ*16-1:0]         o_grant_cnt
`else
    output logic [SRC_W-1:0]            o_src
`endif
);

    localparam int unsigned       CandW = SRC_W + 1;
    localparam logic [CandW-1:0]  NReqC = CandW'(N_REQ);

    logic [N_REQ-1:0]      slot_full;
    logic [N_REQ-1:0]      slot_drain;
    logic [DATA_WIDTH-1:0] slot_data [N_REQ];

    out_state_e            out_q, out_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;

    logic                  grant_found;
    logic [SRC_W-1:0]      grant_idx;
    logic [CandW-1:0]      cand;
    logic                  load;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slot
        retire_arb_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .flush  (i_flush),
            .wr_en  (i_valid[k]),
            .wr_data(i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en  (slot_drain[k]),
            .full   (slot_full[k]),
            .rd_data(slot_data[k])
        );
    end

    // First FULL slot at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + CandW'(i);
            if (cand >= NReqC) begin
                cand = cand - NReqC;
            end
            if (!grant_found && slot_full[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
    end

    assign load = !i_flush && grant_found && ((out_q == OutIdle) || i_ready);

    always_comb begin
        slot_drain = '0;
        if (load) begin
            slot_drain[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_d  = out_q;
        data_d = data_q;
        src_d  = src_q;
        ptr_d  = ptr_q;
        if (i_flush) begin
            out_d = OutIdle;
        end else if (load) begin
            out_d  = OutValid;
            data_d = slot_data[grant_idx];
            src_d  = grant_idx;
            ptr_d  = wrap_inc(grant_idx, N_REQ);
        end else if ((out_q == OutValid) && i_ready) begin
            out_d = OutIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= OutIdle;
            data_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else begin
            out_q  <= out_d;
            data_q <= data_d;
            src_q  <= src_d;
            ptr_q  <= ptr_d;
        end
    end

    assign o_ready = ~slot_full;
    assign o_valid = (out_q == OutValid);
    assign o_data  = data_q;
    assign o_src   = src_q;

`ifdef RETIRE_ARB_GRANT_CNT_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] cnt_d [N_REQ];

    // Counts loads, not downstream accepts; flush leaves the history intact.
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (load && (cnt_q[grant_idx] != 16'hFFFF)) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_cnt_out
        assign o_grant_cnt[k*16 +: 16] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_retire_arb9_rr.sv
// Self-checking bench for retire_arb9_rr: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; counter test only with RETIRE_ARB_GRANT_CNT_EN.
module tb_retire_arb9_rr;

    localparam int N  = 9;
    localparam int DW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_flush;
    logic [N-1:0]      i_valid;
    logic [N*DW-1:0]   i_data;
    logic              i_ready;
    logic [N-1:0]      o_ready;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic [3:0]        o_src;
`ifdef RETIRE_ARB_GRANT_CNT_EN
    logic [N*16-1:0]   o_grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          mf [N];
    logic [DW-1:0] m_slot [N];
    bit          mv;
    logic [DW-1:0] m_odata;
    int          m_src;
    int          mp;
    int          mcnt [N];

    retire_arb9_rr #(
        .DATA_WIDTH(DW),
        .N_REQ     (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
`ifdef RETIRE_ARB_GRANT_CNT_EN
        .o_src      (o_src),
        .o_grant_cnt(o_grant_cnt)
`else
        .o_src      (o_src)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int g;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mf[k]   = 0;
                mcnt[k] = 0;
            end
            mv = 0; m_odata = '0; m_src = 0; mp = 0;
        end else if (i_flush) begin
            for (int k = 0; k < N; k++) mf[k] = 0;
            mv = 0;
        end else begin
            g = -1;
            if (!mv || i_ready) begin
                for (int s = 0; s < N; s++) begin
                    if (g < 0 && mf[(mp + s) % N]) g = (mp + s) % N;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!mf[k] && i_valid[k]) begin
                    mf[k] = 1;
                    m_slot[k] = i_data[k*DW +: DW];
                end
            end
            if (g >= 0) begin
                mf[g] = 0;
                mv = 1;
                m_odata = m_slot[g];
                m_src = g;
                mp = (g + 1) % N;
                if (mcnt[g] < 65535) mcnt[g]++;
            end else if (mv && i_ready) begin
                mv = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = !mf[k];
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        i_valid = '0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic test_reset();
        logic [DW-1:0] d0;
        rst = 1'b1; i_flush = 1'b0; i_valid = '0; i_data = '0; i_ready = 1'b1;
        tick(); tick();
        checks++; if (o_ready !== 9'h1FF) begin
            errors++; $display("FAIL reset_ready: got %h want 1ff", o_ready);
        end
        checks++; if (o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        checks++; if (o_data !== 12'h000) begin
            errors++; $display("FAIL reset_data: got %h want 000", o_data);
        end
        checks++; if (o_src !== 4'd0) begin
            errors++; $display("FAIL reset_src: got %0d want 0", o_src);
        end
        // mid-traffic reset with three slots FULL and an output entry held
        rst = 1'b0; i_ready = 1'b0;
        i_valid = 9'b0_1010_0110;
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'($urandom);
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_ready !== 9'b1_0101_1011) begin
            errors++; $display("FAIL pre_reset_ready: got %h want 15b", o_ready);
        end
        rst = 1'b1; i_valid = 9'h1FF;
        tick();
        checks++; if (o_ready !== 9'h1FF) begin
            errors++; $display("FAIL midreset_ready: got %h want 1ff", o_ready);
        end
        checks++; if (o_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_valid: got %b want 0", o_valid);
        end
        checks++; if (o_src !== 4'd0) begin
            errors++; $display("FAIL midreset_src: got %0d want 0", o_src);
        end
        rst = 1'b0; i_ready = 1'b1; i_valid = 9'h1FF;
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'($urandom);
        d0 = i_data[DW-1:0];
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_src !== 4'd0) begin
            errors++;
            $display("FAIL first_grant: got valid=%b src=%0d want valid=1 src=0", o_valid, o_src);
        end
        checks++; if (o_data !== d0) begin
            errors++; $display("FAIL first_grant_data: got %h want %h", o_data, d0);
        end
        idle_ticks(12);
    endtask

    task automatic test_round_robin();
        int exp_src [3] = '{2, 5, 8};
        logic [DW-1:0] exp_dat [3] = '{12'h222, 12'h555, 12'h888};
        for (int r = 0; r < 2; r++) begin
            i_ready = 1'b1;
            i_data = '0;
            i_data[2*DW +: DW] = 12'h222;
            i_data[5*DW +: DW] = 12'h555;
            i_data[8*DW +: DW] = 12'h888;
            i_valid = 9'b1_0010_0100;
            tick();
            i_valid = '0;
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++;
                if (o_valid !== 1'b1 || o_src !== 4'(exp_src[j]) || o_data !== exp_dat[j]) begin
                    errors++;
                    $display("FAIL rr_round%0d_%0d: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                             r, j, o_valid, o_src, o_data, exp_src[j], exp_dat[j]);
                end
            end
            tick();
            checks++; if (o_valid !== 1'b0) begin
                errors++; $display("FAIL rr_idle%0d: got %b want 0", r, o_valid);
            end
        end
    endtask

    task automatic test_wrap();
        i_ready = 1'b1;
        i_data[7*DW +: DW] = 12'h777;
        i_valid = 9'b0_1000_0000;
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_src !== 4'd7) begin
            errors++; $display("FAIL wrap_setup: got %0d want 7", o_src);
        end
        tick();
        i_data[0 +: DW] = 12'h100;
        i_data[8*DW +: DW] = 12'h800;
        i_valid = 9'b1_0000_0001;
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_src !== 4'd8 || o_data !== 12'h800) begin
            errors++;
            $display("FAIL wrap_first: got src=%0d data=%h want src=8 data=800", o_src, o_data);
        end
        tick();
        checks++; if (o_src !== 4'd0 || o_data !== 12'h100) begin
            errors++;
            $display("FAIL wrap_second: got src=%0d data=%h want src=0 data=100", o_src, o_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        i_data[3*DW +: DW] = 12'hA5C;
        i_data[6*DW +: DW] = 12'h666;
        i_valid = 9'b0_0100_1000;
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_src !== 4'd3 || o_data !== 12'hA5C) begin
            errors++;
            $display("FAIL bp_load: got v=%b src=%0d data=%h want v=1 src=3 data=a5c",
                     o_valid, o_src, o_data);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_src !== 4'd3 || o_data !== 12'hA5C || o_ready[6] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b src=%0d data=%h rdy6=%b want v=1 src=3 data=a5c rdy6=0",
                         c, o_valid, o_src, o_data, o_ready[6]);
            end
        end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b1 || o_src !== 4'd6 || o_data !== 12'h666) begin
            errors++;
            $display("FAIL bp_release: got v=%b src=%0d data=%h want v=1 src=6 data=666",
                     o_valid, o_src, o_data);
        end
        tick();
    endtask

    task automatic test_flush();
        // ptr is 7 here; slot 1 goes to the output, slot 2 stays FULL
        i_ready = 1'b0;
        i_valid = 9'b0_0000_0110;
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_src !== 4'd1) begin
            errors++; $display("FAIL flush_setup: got %0d want 1", o_src);
        end
        i_flush = 1'b1;
        i_valid = 9'b0_0001_0000;
        tick();
        checks++; if (o_ready !== 9'h1FF || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got rdy=%h v=%b want rdy=1ff v=0", o_ready, o_valid);
        end
        i_flush = 1'b0;
        i_ready = 1'b1;
        // ptr must still be 2, so slot 3 wins over slot 0
        i_valid = 9'b0_0000_1001;
        tick();
        i_valid = '0;
        tick();
        checks++; if (o_src !== 4'd3) begin
            errors++; $display("FAIL flush_ptr: got %0d want 3", o_src);
        end
        idle_ticks(4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            i_flush = ($urandom_range(0, 49) == 0);
            i_ready = ($urandom_range(0, 9) < 7);
            i_valid = N'($urandom);
            for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'($urandom);
            tick();
            checks++;
            if (o_ready !== model_ready() || o_valid !== mv ||
                (mv && (o_data !== m_odata || o_src !== 4'(m_src)))) begin
                errors++;
                $display("FAIL random_c%0d: got rdy=%h v=%b src=%0d data=%h want rdy=%h v=%b src=%0d data=%h",
                         c, o_ready, o_valid, o_src, o_data, model_ready(), mv, m_src, m_odata);
            end
        end
        rst = 1'b0;
        idle_ticks(12);
    endtask

`ifdef RETIRE_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        rst = 1'b1;
        tick();
        rst = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_valid = 9'b0_0000_0010;
        for (int c = 0; c < 150000 && mcnt[1] < 65535; c++) tick();
        for (int c = 0; c < 8000; c++) tick();
        i_valid = '0;
        tick();
        checks++; if (o_grant_cnt[31:16] !== 16'hFFFF) begin
            errors++; $display("FAIL grant_cnt_sat: got %h want ffff", o_grant_cnt[31:16]);
        end
        checks++; if (o_grant_cnt[15:0] !== 16'h0000) begin
            errors++; $display("FAIL grant_cnt_other: got %h want 0000", o_grant_cnt[15:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_flush();
        test_random();
`ifdef RETIRE_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
